// File: rtl/prga_decrypt.sv
// RC4 keystream generation and XOR decryption over the encrypted-message ROM.
// Optional plaintext check with early abort: define PRGA_PLAINTEXT_CHECK_EN.
module prga_decrypt #(
   parameter int MSG_LEN = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       done,
   output logic [7:0] s_addr,
   output logic [7:0] s_wdata,
   output logic       s_wren,
   input  logic [7:0] s_rdata,
   output logic [7:0] rom_addr,
   input  logic [7:0] rom_rdata,
   output logic [7:0] d_addr,
   output logic [7:0] d_wdata,
   output logic       d_wren,
   output logic       msg_valid
);

   localparam logic [3:0] IDLE    = 4'd0;
   localparam logic [3:0] ADDR_I  = 4'd1;
   localparam logic [3:0] READ_I  = 4'd2;
   localparam logic [3:0] ADDR_J  = 4'd3;
   localparam logic [3:0] READ_J  = 4'd4;
   localparam logic [3:0] WRITE_I = 4'd5;
   localparam logic [3:0] WRITE_J = 4'd6;
   localparam logic [3:0] ADDR_F  = 4'd7;
   localparam logic [3:0] OUT     = 4'd8;
   localparam logic [3:0] DONE    = 4'd9;

   localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

   logic [3:0] state_reg;
   logic [7:0] i_reg;
   logic [7:0] j_reg;
   logic [7:0] k_reg;
   logic [7:0] si_reg;
   logic [7:0] sj_reg;
   logic       valid_reg;

   logic [7:0] plain_byte;
   logic       byte_ok;

   // In OUT, s_rdata holds S[si+sj] and rom_rdata holds ROM[k].
   assign plain_byte = s_rdata ^ rom_rdata;

`ifdef PRGA_PLAINTEXT_CHECK_EN
   assign byte_ok = (plain_byte == 8'h20) ||
                    ((plain_byte >= 8'h61) && (plain_byte <= 8'h7a));
`else
   assign byte_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         i_reg     <= 8'd0;
         j_reg     <= 8'd0;
         k_reg     <= 8'd0;
         si_reg    <= 8'd0;
         sj_reg    <= 8'd0;
         valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  state_reg <= ADDR_I;
                  i_reg     <= 8'd1;
                  j_reg     <= 8'd0;
                  k_reg     <= 8'd0;
                  valid_reg <= 1'b1;
               end
            end
            ADDR_I: state_reg <= READ_I;
            READ_I: begin
               si_reg    <= s_rdata;
               j_reg     <= j_reg + s_rdata;
               state_reg <= ADDR_J;
            end
            ADDR_J: state_reg <= READ_J;
            READ_J: begin
               sj_reg    <= s_rdata;
               state_reg <= WRITE_I;
            end
            WRITE_I: state_reg <= WRITE_J;
            WRITE_J: state_reg <= ADDR_F;
            ADDR_F:  state_reg <= OUT;
            OUT: begin
               i_reg <= i_reg + 8'd1;
               k_reg <= k_reg + 8'd1;
               if (!byte_ok) begin
                  // Failing byte is still written; stop the run here.
                  valid_reg <= 1'b0;
                  state_reg <= DONE;
               end else if (k_reg == LAST_K) begin
                  state_reg <= DONE;
               end else begin
                  state_reg <= ADDR_I;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_comb begin
      s_addr   = 8'd0;
      s_wdata  = 8'd0;
      s_wren   = 1'b0;
      rom_addr = 8'd0;
      d_addr   = 8'd0;
      d_wdata  = 8'd0;
      d_wren   = 1'b0;
      case (state_reg)
         ADDR_I: s_addr = i_reg;
         ADDR_J: s_addr = j_reg;
         WRITE_I: begin
            s_addr  = i_reg;
            s_wdata = sj_reg;
            s_wren  = 1'b1;
         end
         // When i == j this second write lands on the same cell with si == sj.
         WRITE_J: begin
            s_addr  = j_reg;
            s_wdata = si_reg;
            s_wren  = 1'b1;
         end
         ADDR_F: begin
            s_addr   = si_reg + sj_reg;
            rom_addr = k_reg;
         end
         OUT: begin
            d_addr  = k_reg;
            d_wdata = plain_byte;
            d_wren  = 1'b1;
         end
         default: ;
      endcase
   end

   assign done      = (state_reg == DONE);
   assign msg_valid = valid_reg;

endmodule

// File: tb/tb_prga_decrypt.sv
// Bench for prga_decrypt: RAM/ROM models plus a plain RC4 reference that
// predicts plaintext, write timing, final S contents and msg_valid.
module tb_prga_decrypt;

   localparam int L = 32;
`ifdef PRGA_PLAINTEXT_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       start;
   logic       done;
   logic [7:0] s_addr;
   logic [7:0] s_wdata;
   logic       s_wren;
   logic [7:0] s_rdata;
   logic [7:0] rom_addr;
   logic [7:0] rom_rdata;
   logic [7:0] d_addr;
   logic [7:0] d_wdata;
   logic       d_wren;
   logic       msg_valid;

   logic [7:0] s_ram  [256];
   logic [7:0] s_load [256];
   logic [7:0] rom    [256];
   logic [7:0] d_ram  [256];
   logic [7:0] m_s    [256];
   logic [7:0] m_d    [256];
   logic [7:0] s_pre  [256];
   logic       preload;
   logic       clear_d;

   int cyc = 0;
   int last_wr = 0;
   int wq[$];
   int checks = 0;
   int fails = 0;

   prga_decrypt #(.MSG_LEN(L)) dut (
      .clk(clk), .reset(reset), .start(start), .done(done),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
      .rom_addr(rom_addr), .rom_rdata(rom_rdata),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_wren(d_wren),
      .msg_valid(msg_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (preload) begin
         for (int x = 0; x < 256; x++) s_ram[x] <= s_load[x];
      end else if (s_wren) begin
         s_ram[s_addr] <= s_wdata;
      end
      s_rdata   <= s_ram[s_addr];
      rom_rdata <= rom[rom_addr];
      if (clear_d) begin
         for (int x = 0; x < 256; x++) d_ram[x] <= 8'h00;
      end else if (d_wren) begin
         d_ram[d_addr] <= d_wdata;
      end
   end

   // Write monitor: d_wren cycle numbers and the last cycle with any write.
   always @(negedge clk) begin
      if (d_wren) wq.push_back(cyc);
      if (s_wren || d_wren) last_wr <= cyc;
   end

   // ---------------- reference model ----------------
   task automatic model_run(input int n, input bit chk, output int nw, output bit ok);
      logic [7:0] i, j, t, pt;
      j  = 8'd0;
      ok = 1'b1;
      nw = n;
      for (int k = 0; k < n; k++) begin
         i = 8'(k + 1);
         j = j + m_s[i];
         t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
         pt = rom[k] ^ m_s[8'(m_s[i] + m_s[j])];
         m_d[k] = pt;
         if (chk && !(pt == 8'h20 || (pt >= 8'h61 && pt <= 8'h7a))) begin
            ok = 1'b0;
            nw = k + 1;
            break;
         end
      end
   endtask

   // Builds a ROM whose plaintext is lowercase/space under the current m_s;
   // leaves the raw keystream in m_d.
   task automatic make_rom(input int n);
      logic [7:0] keep [256];
      logic [7:0] letter;
      int nw;
      bit ok;
      keep = m_s;
      for (int x = 0; x < 256; x++) rom[x] = 8'h00;
      model_run(n, 1'b0, nw, ok);
      for (int k = 0; k < n; k++) begin
         letter = ($urandom_range(26, 0) == 0) ? 8'h20 : 8'(8'h61 + $urandom_range(25, 0));
         rom[k] = m_d[k] ^ letter;
      end
      m_s = keep;
   endtask

   task automatic ksa_key249();
      logic [7:0] key [3];
      logic [7:0] j, t;
      key[0] = 8'h00; key[1] = 8'h02; key[2] = 8'h49;
      for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
      j = 8'd0;
      for (int x = 0; x < 256; x++) begin
         j = j + m_s[x] + key[x % 3];
         t = m_s[x]; m_s[x] = m_s[j]; m_s[j] = t;
      end
   endtask

   task automatic shuffle_s();
      logic [7:0] t;
      int r;
      for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
      for (int x = 255; x > 0; x--) begin
         r = $urandom_range(x, 0);
         t = m_s[x]; m_s[x] = m_s[r]; m_s[r] = t;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic load_s_and_clear_d();
      for (int x = 0; x < 256; x++) s_load[x] = m_s[x];
      @(negedge clk);
      preload = 1'b1;
      clear_d = 1'b1;
      @(negedge clk);
      preload = 1'b0;
      clear_d = 1'b0;
   endtask

   task automatic pulse_start(output int t0);
      @(negedge clk);
      start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int dc);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      dc = (done === 1'b1) ? cyc : -1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({done, s_wren, d_wren, msg_valid} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_flags: got done/s_wren/d_wren/msg_valid=%b expected 0000",
                  {done, s_wren, d_wren, msg_valid});
      end
      checks++;
      if ({s_addr, s_wdata, rom_addr, d_addr, d_wdata} !== 40'd0) begin
         fails++;
         $display("FAIL reset_buses: got s_addr=%h s_wdata=%h rom_addr=%h d_addr=%h d_wdata=%h expected all 00",
                  s_addr, s_wdata, rom_addr, d_addr, d_wdata);
      end
      reset = 1'b0;
      @(negedge clk);
      $display("reset: outputs sampled under reset");
   endtask

   task automatic test_identity();
      int t0, nw, dc;
      bit ok;
      for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
      load_s_and_clear_d();
      for (int x = 0; x < 256; x++) rom[x] = 8'($urandom);
      rom[0] = 8'h41;
      rom[1] = 8'h00;
      pulse_start(t0);
      model_run(L, CHK, nw, ok);
      while (cyc < t0 + 17) @(negedge clk);
      checks++;
      if (d_ram[0] !== 8'h43) begin
         fails++;
         $display("FAIL identity_d0: got %h expected 43", d_ram[0]);
      end
`ifndef PRGA_PLAINTEXT_CHECK_EN
      checks++;
      if (d_ram[1] !== 8'h05) begin
         fails++;
         $display("FAIL identity_d1: got %h expected 05", d_ram[1]);
      end
      checks++;
      if (s_ram[2] !== 8'h03 || s_ram[3] !== 8'h02) begin
         fails++;
         $display("FAIL identity_swap: got S[2]=%h S[3]=%h expected 03 02", s_ram[2], s_ram[3]);
      end
`endif
      wait_done(dc);
      for (int k = 0; k < nw; k++) begin
         checks++;
         if (d_ram[k] !== m_d[k]) begin
            fails++;
            $display("FAIL identity_data[%0d]: got %h expected %h", k, d_ram[k], m_d[k]);
         end
      end
      checks++;
      if (msg_valid !== ok) begin
         fails++;
         $display("FAIL identity_valid: got %b expected %b", msg_valid, ok);
      end
      $display("identity: %0d bytes expected, done at cycle %0d", nw, dc - t0);
   endtask

   task automatic test_key_timing();
      int t0, nw, dc, base, sbad;
      bit ok;
      ksa_key249();
      load_s_and_clear_d();
      make_rom(L);
      base = wq.size();
      pulse_start(t0);
      model_run(L, CHK, nw, ok);
      wait_done(dc);
      checks++;
      if (dc - t0 !== 8 * nw + 1) begin
         fails++;
         $display("FAIL key_done_cycle: got %0d expected %0d", dc - t0, 8 * nw + 1);
      end
      checks++;
      if (wq.size() - base !== nw) begin
         fails++;
         $display("FAIL key_write_count: got %0d expected %0d", wq.size() - base, nw);
      end else begin
         for (int k = 0; k < nw; k++) begin
            checks++;
            if (wq[base + k] - t0 !== 8 * k + 8) begin
               fails++;
               $display("FAIL key_write_cycle[%0d]: got %0d expected %0d", k, wq[base + k] - t0, 8 * k + 8);
            end
         end
      end
      for (int k = 0; k < nw; k++) begin
         checks++;
         if (d_ram[k] !== m_d[k]) begin
            fails++;
            $display("FAIL key_data[%0d]: got %h expected %h", k, d_ram[k], m_d[k]);
         end
      end
      sbad = 0;
      for (int x = 0; x < 256; x++) if (s_ram[x] !== m_s[x]) sbad++;
      checks++;
      if (sbad != 0) begin
         fails++;
         $display("FAIL key_s_state: got %0d differing S entries expected 0", sbad);
      end
      checks++;
      if (msg_valid !== 1'b1) begin
         fails++;
         $display("FAIL key_valid: got %b expected 1", msg_valid);
      end
      $display("key_000249: %0d bytes, done at cycle %0d", wq.size() - base, dc - t0);
   endtask

   task automatic test_reset_mid();
      int t0, t1, nw, dc, base;
      bit ok;
      shuffle_s();
      s_pre = m_s;
      load_s_and_clear_d();
      make_rom(L);
      base = wq.size();
      pulse_start(t0);
      while (cyc < t0 + 40) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({done, s_wren, d_wren, msg_valid} !== 4'b0000) begin
         fails++;
         $display("FAIL midreset_idle: got done/s_wren/d_wren/msg_valid=%b at cycle %0d expected 0000",
                  {done, s_wren, d_wren, msg_valid}, cyc - t0);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (last_wr - t0 !== 40) begin
         fails++;
         $display("FAIL midreset_last_write: got cycle %0d expected 40", last_wr - t0);
      end
      checks++;
      if (wq.size() - base !== 5) begin
         fails++;
         $display("FAIL midreset_partial_count: got %0d expected 5", wq.size() - base);
      end
      m_s = s_pre;
      model_run(5, CHK, nw, ok);
      load_s_and_clear_d_keep();
      pulse_start(t1);
      model_run(L, CHK, nw, ok);
      wait_done(dc);
      checks++;
      if (dc - t1 !== 8 * nw + 1) begin
         fails++;
         $display("FAIL midreset_rerun_done: got %0d expected %0d", dc - t1, 8 * nw + 1);
      end
      for (int k = 0; k < nw; k++) begin
         checks++;
         if (d_ram[k] !== m_d[k]) begin
            fails++;
            $display("FAIL midreset_rerun_data[%0d]: got %h expected %h", k, d_ram[k], m_d[k]);
         end
      end
      checks++;
      if (msg_valid !== ok) begin
         fails++;
         $display("FAIL midreset_rerun_valid: got %b expected %b", msg_valid, ok);
      end
      $display("reset_mid: rerun %0d bytes, done at cycle %0d", nw, dc - t1);
   endtask

   // Clears D only; S stays as the DUT left it.
   task automatic load_s_and_clear_d_keep();
      @(negedge clk);
      clear_d = 1'b1;
      @(negedge clk);
      clear_d = 1'b0;
   endtask

   task automatic test_start_ignore_restart();
      int t0, t1, nw, dc, base, sbad;
      bit ok;
      shuffle_s();
      load_s_and_clear_d();
      make_rom(L);
      base = wq.size();
      pulse_start(t0);
      model_run(L, CHK, nw, ok);
      while (cyc < t0 + 20) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(dc);
      checks++;
      if (dc - t0 !== 8 * nw + 1) begin
         fails++;
         $display("FAIL ignore_done_cycle: got %0d expected %0d", dc - t0, 8 * nw + 1);
      end
      checks++;
      if (wq.size() - base !== nw) begin
         fails++;
         $display("FAIL ignore_write_count: got %0d expected %0d", wq.size() - base, nw);
      end
      repeat (3) @(negedge clk);
      load_s_and_clear_d_keep();
      base = wq.size();
      pulse_start(t1);
      checks++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL restart_done_low: got %b expected 0", done);
      end
      model_run(L, CHK, nw, ok);
      wait_done(dc);
      checks++;
      if (wq.size() <= base || wq[base] - t1 !== 8) begin
         fails++;
         $display("FAIL restart_first_write: got %0d writes, first at %0d expected cycle 8",
                  wq.size() - base, (wq.size() > base) ? wq[base] - t1 : -1);
      end
      checks++;
      if (dc - t1 !== 8 * nw + 1) begin
         fails++;
         $display("FAIL restart_done_cycle: got %0d expected %0d", dc - t1, 8 * nw + 1);
      end
      for (int k = 0; k < nw; k++) begin
         checks++;
         if (d_ram[k] !== m_d[k]) begin
            fails++;
            $display("FAIL restart_data[%0d]: got %h expected %h", k, d_ram[k], m_d[k]);
         end
      end
      sbad = 0;
      for (int x = 0; x < 256; x++) if (s_ram[x] !== m_s[x]) sbad++;
      checks++;
      if (sbad != 0) begin
         fails++;
         $display("FAIL restart_s_state: got %0d differing S entries expected 0", sbad);
      end
      $display("restart: %0d bytes, done at cycle %0d", nw, dc - t1);
   endtask

   task automatic test_plaintext_abort();
      int t0, nw, dc, base;
      bit ok;
      shuffle_s();
      load_s_and_clear_d();
      make_rom(L);
      rom[3] = m_d[3] ^ 8'h7b;
      base = wq.size();
      pulse_start(t0);
      model_run(L, CHK, nw, ok);
      wait_done(dc);
`ifdef PRGA_PLAINTEXT_CHECK_EN
      checks++;
      if (wq.size() - base !== 4 || dc - t0 !== 33 || msg_valid !== 1'b0) begin
         fails++;
         $display("FAIL abort_spec: got writes=%0d done=%0d valid=%b expected 4 33 0",
                  wq.size() - base, dc - t0, msg_valid);
      end
`else
      checks++;
      if (wq.size() - base !== L || msg_valid !== 1'b1) begin
         fails++;
         $display("FAIL noabort_spec: got writes=%0d valid=%b expected %0d 1",
                  wq.size() - base, msg_valid, L);
      end
`endif
      checks++;
      if (dc - t0 !== 8 * nw + 1) begin
         fails++;
         $display("FAIL abort_done_cycle: got %0d expected %0d", dc - t0, 8 * nw + 1);
      end
      for (int k = 0; k < nw; k++) begin
         checks++;
         if (d_ram[k] !== m_d[k]) begin
            fails++;
            $display("FAIL abort_data[%0d]: got %h expected %h", k, d_ram[k], m_d[k]);
         end
      end
      checks++;
      if (msg_valid !== ok) begin
         fails++;
         $display("FAIL abort_valid: got %b expected %b", msg_valid, ok);
      end
      $display("plaintext_7b: %0d bytes written, msg_valid=%b", wq.size() - base, msg_valid);
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      preload = 1'b0;
      clear_d = 1'b0;
      for (int x = 0; x < 256; x++) begin
         rom[x]    = 8'h00;
         s_load[x] = 8'h00;
      end
      test_reset();
      test_identity();
      test_key_timing();
      test_reset_mid();
      test_start_ignore_restart();
      test_plaintext_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
